// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer packet path: header codes,
// field positions, packer FSM states and a repeat-packet builder.
package la_pkg;

  localparam logic [1:0] LA_HDR_SAMPLE = 2'b10;
  localparam logic [1:0] LA_HDR_REPEAT = 2'b11;

  localparam int LA_ADDR_MSB = 31;
  localparam int LA_ADDR_LSB = 28;
  localparam int LA_HDR_MSB  = 27;
  localparam int LA_HDR_LSB  = 26;
  localparam int LA_PINS_MSB = 15;
  localparam int LA_PINS_LSB = 0;

  typedef enum logic [1:0] {
    EMPTY,
    RUN,
    FLUSH
  } la_state_e;

  function automatic logic [31:0] la_repeat_pkt(input logic [3:0]  addr,
                                                input logic [15:0] count);
    return {addr, LA_HDR_REPEAT, 10'b0, count};
  endfunction

endpackage

// File: rtl/la_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. A push while full is accepted
// only if a pop frees the head slot in the same cycle.
module la_sync_fifo #(
  parameter int width = 32,
  parameter int depth = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic [width-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en, rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign head  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is deliberately not reset; the empty flag masks stale words at the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/la_rle_packer.sv
// Run-length packer: collapses consecutive identical pin samples into repeat
// packets and queues all output packets in a FWFT FIFO.
module la_rle_packer
  import la_pkg::*;
#(
  parameter int width      = 32,
  parameter int fifo_depth = 16,
  parameter int max_run    = 65535
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] packet_in,
  input  logic             in_valid,
  input  logic             flush,
  output logic [width-1:0] packet_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overflow
);

  localparam logic [15:0] MAX_RUN = 16'(max_run);

  la_state_e        state_q, state_d;
  logic [15:0]      ref_q, ref_d;
  logic [3:0]       addr_q, addr_d;
  logic [15:0]      count_q, count_d;
  logic [width-1:0] pend_q, pend_d;
  logic             pflush_q, pflush_d;
  logic             overflow_q, overflow_d;

  logic             push;
  logic [width-1:0] push_data;
  logic             fifo_full, fifo_empty, fifo_pop;
  logic             match, do_flush;
  logic [15:0]      count_inc;

  assign match     = (packet_in[LA_PINS_MSB:LA_PINS_LSB] == ref_q);
  assign count_inc = count_q + 16'd1;
  // A flush that collided with in_valid last cycle is replayed from pflush_q.
  assign do_flush  = pflush_q || (flush && !in_valid);
  assign fifo_pop  = out_ready && !fifo_empty;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    addr_d    = addr_q;
    count_d   = count_q;
    pend_d    = pend_q;
    pflush_d  = 1'b0;
    push      = 1'b0;
    push_data = '0;
    unique case (state_q)
      EMPTY: begin
        if (in_valid) begin
          push      = 1'b1;
          push_data = packet_in;
          ref_d     = packet_in[LA_PINS_MSB:LA_PINS_LSB];
          addr_d    = packet_in[LA_ADDR_MSB:LA_ADDR_LSB];
          count_d   = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          pflush_d = flush;
          if (match) begin
            if (count_inc == MAX_RUN) begin
              push      = 1'b1;
              push_data = la_repeat_pkt(addr_q, MAX_RUN);
              count_d   = '0;
            end else begin
              count_d = count_inc;
            end
          end else if (count_q != '0) begin
            push      = 1'b1;
            push_data = la_repeat_pkt(addr_q, count_q);
            pend_d    = packet_in;
            count_d   = '0;
            state_d   = FLUSH;
          end else begin
            push      = 1'b1;
            push_data = packet_in;
            ref_d     = packet_in[LA_PINS_MSB:LA_PINS_LSB];
            addr_d    = packet_in[LA_ADDR_MSB:LA_ADDR_LSB];
          end
        end else if (do_flush && count_q != '0) begin
          push      = 1'b1;
          push_data = la_repeat_pkt(addr_q, count_q);
          count_d   = '0;
        end
      end
      FLUSH: begin
        push      = 1'b1;
        push_data = pend_q;
        ref_d     = pend_q[LA_PINS_MSB:LA_PINS_LSB];
        addr_d    = pend_q[LA_ADDR_MSB:LA_ADDR_LSB];
        count_d   = '0;
        state_d   = RUN;
      end
      default: state_d = EMPTY;
    endcase
    overflow_d = overflow_q || (push && fifo_full && !fifo_pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      ref_q      <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      pflush_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      pflush_q   <= pflush_d;
      overflow_q <= overflow_d;
    end
  end

  la_sync_fifo #(
    .width (width),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (packet_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_la_rle_packer.sv
// Directed bench for la_rle_packer; max_run is scaled down to 8 so the
// run-limit case completes in a handful of cycles.
module tb_la_rle_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] packet_in = '0;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] packet_out;
  logic        out_valid;
  logic        overflow;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cap_q[$];

  la_rle_packer #(
    .width      (32),
    .fifo_depth (16),
    .max_run    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .packet_in  (packet_in),
    .in_valid   (in_valid),
    .flush      (flush),
    .packet_out (packet_out),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so the falling edge sees the settled handshake.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) cap_q.push_back(packet_out);
  end

  function automatic logic [31:0] sp(input logic [3:0] addr, input logic [15:0] pins);
    return {addr, 2'b10, 10'b0, pins};
  endfunction

  function automatic logic [31:0] rp(input logic [3:0] addr, input logic [15:0] cnt);
    return {addr, 2'b11, 10'b0, cnt};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] addr, input logic [15:0] pins, input logic fl = 1'b0);
    @(posedge clk);
    #1;
    packet_in = sp(addr, pins);
    in_valid  = 1'b1;
    flush     = fl;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic pulse_flush();
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic expect_pkt(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    int          w;
    got = 'x;
    w   = 0;
    while (cap_q.size() == 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (cap_q.size() != 0) got = cap_q.pop_front();
    check(tag, got, exp);
  endtask

  task automatic expect_idle(input string tag);
    tick(6);
    check(tag, 32'(cap_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_packet_out", packet_out, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);
    rst = 1'b1;
    tick(2);

    // Three distinct samples pass straight through
    send(4'h5, 16'h0001);
    send(4'h5, 16'h0002);
    send(4'h5, 16'h0003);
    expect_pkt("pass_1", 32'h5800_0001);
    expect_pkt("pass_2", 32'h5800_0002);
    expect_pkt("pass_3", 32'h5800_0003);
    expect_idle("pass_no_extra");

    // Five AA (address ignored in compare) then BB
    send(4'h5, 16'h00AA);
    send(4'h9, 16'h00AA);
    send(4'h5, 16'h00AA);
    send(4'h5, 16'h00AA);
    send(4'h5, 16'h00AA);
    send(4'h3, 16'h00BB);
    expect_pkt("run_sample", 32'h5800_00AA);
    expect_pkt("run_repeat4", 32'h5C00_0004);
    expect_pkt("run_next", 32'h3800_00BB);
    expect_idle("run_no_extra");

    // Ten samples of 1234 with max_run=8: sample, repeat 8, then 1 pending
    for (int i = 0; i < 10; i++) send(4'h2, 16'h1234);
    expect_pkt("max_sample", 32'h2800_1234);
    expect_pkt("max_repeat", 32'h2C00_0008);
    expect_idle("max_pending_held");
    pulse_flush();
    expect_pkt("max_flush1", 32'h2C00_0001);
    expect_idle("max_no_extra");

    // Flush colliding with a matching sample at count=2
    send(4'h1, 16'h0055);
    send(4'h1, 16'h0055);
    send(4'h1, 16'h0055);
    send(4'h1, 16'h0055, 1'b1);
    expect_pkt("coll_sample", 32'h1800_0055);
    expect_pkt("coll_repeat3", 32'h1C00_0003);
    expect_idle("coll_no_extra");
    check("pre_ovf_clear", {31'b0, overflow}, 32'd0);

    // Back-pressure: 20 distinct samples into a 16-entry FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) send(4'h7, 16'h0100 + 16'(i));
    check("ovf_flag", {31'b0, overflow}, 32'd1);
    check("ovf_valid", {31'b0, out_valid}, 32'd1);
    check("ovf_head", packet_out, 32'h7800_0100);
    tick(3);
    check("ovf_head_stable", packet_out, 32'h7800_0100);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) expect_pkt($sformatf("drain_%0d", i), sp(4'h7, 16'h0100 + 16'(i)));
    expect_idle("drain_exact16");
    check("ovf_sticky", {31'b0, overflow}, 32'd1);

    // Reset mid-run with count=7 and FIFO non-empty
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'h4, 16'h0777);
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_overflow", {31'b0, overflow}, 32'd0);
    check("mid_rst_packet", packet_out, 32'd0);
    tick(2);
    rst = 1'b1;
    out_ready = 1'b1;
    tick(1);
    send(4'h4, 16'h0777);
    expect_pkt("post_rst_fresh", 32'h4800_0777);
    expect_idle("post_rst_no_extra");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
